// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, flag bit
// positions inside the 4-bit flag vector, and a helper that assembles that
// vector from its individual bits.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SBC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;

  localparam int FLG_N = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 3;

  typedef logic [3:0] flg_t;

  function automatic flg_t pack_flags(input logic c, input logic z,
                                      input logic v, input logic n);
    flg_t f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_Z] = z;
    f[FLG_V] = v;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : latch a/b and begin (ignored while busy)
//   a, b      : WIDTH-bit operands
//   busy      : multiplication in progress
//   done      : high during the last step; product is valid in that cycle
//   product   : 2*WIDTH-bit running sum including the current step
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // The step's sum is exposed combinationally so the parent can register the
  // final result on the same edge that retires the last step.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and persistent NZVC flags.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand/op handshake
//   op, a, b            : opcode, operands (shift amount in b[SHW-1:0])
//   out_valid, out_ready: result handshake
//   res, flg            : registered result and flags {C,Z,V,N}
//   busy                : multiply in progress
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output flg_t             flg,
  output logic             busy
);

  logic             accept;
  logic             is_mul;
  logic [SHW-1:0]   sh;
  logic             mul_busy;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic             mul_hi;
  flg_t             mul_flg;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  flg_t             alu_flg;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;

  assign sh       = b[SHW-1:0];
  assign is_mul   = (MUL_EN != 0) && (op == OP_MUL);
  assign busy     = mul_busy;
  assign in_ready = !mul_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  generate
    if (MUL_EN != 0) begin : gen_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : gen_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  assign mul_hi  = |mul_product[2*WIDTH-1:WIDTH];
  assign mul_flg = pack_flags(mul_hi, mul_product[WIDTH-1:0] == '0, mul_hi,
                              mul_product[WIDTH-1]);

  // Single-cycle datapath. The defaults describe the reserved opcodes
  // (pass a, keep C/V); a shift by zero also keeps those defaults for res/C.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    alu_res = a;
    alu_c   = flg[FLG_C];
    alu_v   = flg[FLG_V];
    b_eff   = b;
    cin     = 1'b0;
    sum     = '0;
    shl_w   = '0;
    shr_w   = '0;
    case (op)
      OP_AND: begin alu_res = a & b; alu_v = 1'b0; end
      OP_OR:  begin alu_res = a | b; alu_v = 1'b0; end
      OP_XOR: begin alu_res = a ^ b; alu_v = 1'b0; end
      OP_NOT: begin alu_res = ~a;    alu_v = 1'b0; end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        b_eff = (op == OP_SUB || op == OP_SBC) ? ~b : b;
        // ADC/SBC chain on the stored carry, which already reflects the
        // op retired on the previous edge.
        cin   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : flg[FLG_C];
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      // Shifts run one bit wider so the last bit shifted out lands in the
      // extra position and becomes C.
      OP_SHL: begin
        alu_v = 1'b0;
        if (sh != '0) begin
          shl_w   = {1'b0, a} << sh;
          alu_res = shl_w[WIDTH-1:0];
          alu_c   = shl_w[WIDTH];
        end
      end
      OP_SHR: begin
        alu_v = 1'b0;
        if (sh != '0) begin
          shr_w   = {a, 1'b0} >> sh;
          alu_res = shr_w[WIDTH:1];
          alu_c   = shr_w[0];
        end
      end
      OP_SAR: begin
        alu_v = 1'b0;
        if (sh != '0) begin
          shr_w   = $unsigned($signed({a, 1'b0}) >>> sh);
          alu_res = shr_w[WIDTH:1];
          alu_c   = shr_w[0];
        end
      end
      default: ;
    endcase
    alu_flg = pack_flags(alu_c, alu_res == '0, alu_v, alu_res[WIDTH-1]);
  end

  // Result register. A multiply cannot finish in a cycle that accepts,
  // because in_ready is low while the multiplier is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      flg       <= '0;
      out_valid <= 1'b0;
    end else if (mul_done) begin
      res       <= mul_product[WIDTH-1:0];
      flg       <= mul_flg;
      out_valid <= 1'b1;
    end else if (accept && !is_mul) begin
      res       <= alu_res;
      flg       <= alu_flg;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, MUL_EN=1): directed vectors with
// literal expectations plus a scoreboard fed by an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] res;
  flg_t       flg;
  logic       busy;

  alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flg       (flg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  // Reference model: plain integer arithmetic on the op's meaning.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                 input logic [7:0] y, input logic [3:0] f);
    int ux, uy, sx, sy, sh, full, s, brw;
    logic c, v;
    logic [7:0] r;
    exp_t e;
    ux = int'(x);  uy = int'(y);
    sx = int'($signed(x));  sy = int'($signed(y));
    sh = uy % 8;
    c = f[3];  v = f[1];  r = x;
    case (o)
      OP_AND: begin r = x & y; v = 1'b0; end
      OP_OR:  begin r = x | y; v = 1'b0; end
      OP_XOR: begin r = x ^ y; v = 1'b0; end
      OP_NOT: begin r = ~x;    v = 1'b0; end
      OP_ADD: begin full = ux + uy; r = 8'(full); c = full > 255;
                    s = sx + sy; v = (s > 127) || (s < -128); end
      OP_ADC: begin full = ux + uy + int'(f[3]); r = 8'(full); c = full > 255;
                    s = sx + sy + int'(f[3]); v = (s > 127) || (s < -128); end
      OP_SUB: begin r = 8'(ux - uy); c = ux >= uy;
                    s = sx - sy; v = (s > 127) || (s < -128); end
      OP_SBC: begin brw = 1 - int'(f[3]); r = 8'(ux - uy - brw); c = ux >= uy + brw;
                    s = sx - sy - brw; v = (s > 127) || (s < -128); end
      OP_SHL: begin v = 1'b0;
                    if (sh != 0) begin r = 8'(ux << sh); c = ((ux >> (8 - sh)) & 1) != 0; end end
      OP_SHR: begin v = 1'b0;
                    if (sh != 0) begin r = 8'(ux >> sh); c = ((ux >> (sh - 1)) & 1) != 0; end end
      OP_SAR: begin v = 1'b0;
                    if (sh != 0) begin r = 8'(sx >>> sh); c = ((ux >> (sh - 1)) & 1) != 0; end end
      OP_MUL: begin full = ux * uy; r = 8'(full); c = (full >> 8) != 0; v = c; end
      default: ;
    endcase
    e.res = r;
    e.flg = {c, r == 8'h00, v, r[7]};
    return e;
  endfunction

  exp_t       q[$];
  logic [3:0] model_flg = 4'h0;

  // Compare process: every cycle with out_valid the outputs must match the
  // oldest outstanding expectation; accepts feed the model in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      model_flg = 4'h0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) check("out_valid_without_op", 32'(out_valid), 32'd0);
        else begin
          check("model_res", 32'(res), 32'(q[0].res));
          check("model_flg", 32'(flg), 32'(q[0].flg));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = model(op, a, b, model_flg);
        q.push_back(e);
        model_flg = e.flg;
      end
    end
  end

  // Present an op and wait (bounded) for its accept edge; returns at
  // accept edge + 1 with in_valid still high.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int acc_cyc);
    op = o;  a = x;  b = y;  in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      n_checks++;
      $display("FAIL accept_timeout: op 0x%0h never accepted", o);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] o;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t tbl[16] = '{
    '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000},
    '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 4'b0001},
    '{OP_NOT, 8'h5A, 8'h00, 8'hA5, 4'b0001},
    '{OP_SBC, 8'h10, 8'h01, 8'h0E, 4'b1000},
    '{OP_ADC, 8'h7F, 8'h7F, 8'hFF, 4'b0011},
    '{OP_SHR, 8'hC0, 8'h07, 8'h01, 4'b1000},
    '{OP_SHL, 8'h81, 8'h03, 8'h08, 4'b0000},
    '{OP_SAR, 8'h80, 8'h07, 8'hFF, 4'b0001},
    '{4'hD,   8'h00, 8'h55, 8'h00, 4'b0100},
    '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b1010},
    '{4'hF,   8'h80, 8'h00, 8'h80, 4'b1011},
    '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b0001},
    '{OP_SBC, 8'h80, 8'h00, 8'h7F, 4'b1010},
    '{OP_SHR, 8'h81, 8'h09, 8'h40, 4'b1000},
    '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b1100},
    '{OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, c4, c5, c6, c7;
    bit ok;

    // Reset state
    #2;
    check("rst_res",       32'(res),       32'h00);
    check("rst_flg",       32'(flg),       32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD overflow into sign bit; result visible right after the accept edge
    issue(OP_ADD, 8'h7F, 8'h01, c0);
    check("add7f_out_valid", 32'(out_valid), 32'd1);
    check("add7f_res", 32'(res), 32'h80);
    check("add7f_flg", 32'(flg), 32'b0011);

    // Carry chain back-to-back
    issue(OP_ADD, 8'hFF, 8'h01, c1);
    check("addff_res", 32'(res), 32'h00);
    check("addff_flg", 32'(flg), 32'b1100);
    issue(OP_ADC, 8'h00, 8'h00, c2);
    check("adc_throughput", 32'(c2 - c1), 32'd1);
    check("adc_res", 32'(res), 32'h01);
    check("adc_flg", 32'(flg), 32'b0000);
    issue(OP_SUB, 8'h05, 8'h05, c3);
    check("sub_res", 32'(res), 32'h00);
    check("sub_flg", 32'(flg), 32'b1100);
    idle(1);

    // Multi-cycle multiply
    issue(OP_MUL, 8'h10, 8'h11, c4);
    in_valid = 1'b0;
    check("mul_busy_start",     32'(busy),      32'd1);
    check("mul_in_ready_start", 32'(in_ready),  32'd0);
    check("mul_out_valid_start",32'(out_valid), 32'd0);
    ok = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid || !busy || in_ready) ok = 1'b0;
    end
    check("mul_wait_window", 32'(ok), 32'd1);
    @(posedge clk); #1;
    check("mul_latency",   32'(cyc - c4),  32'd8);
    check("mul_out_valid", 32'(out_valid), 32'd1);
    check("mul_busy_end",  32'(busy),      32'd0);
    check("mul_res",       32'(res),       32'h10);
    check("mul_flg",       32'(flg),       32'b1010);
    idle(1);

    // Back-pressure: result held, pending op waits
    out_ready = 1'b0;
    issue(OP_ADD, 8'h7F, 8'h01, c5);
    check("hold_res0", 32'(res), 32'h80);
    op = OP_XOR;  a = 8'h0F;  b = 8'hFF;  in_valid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (res !== 8'h80 || flg !== 4'b0011 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("hold_stable", 32'(ok), 32'd1);
    out_ready = 1'b1;
    #0;
    check("hold_release_in_ready", 32'(in_ready), 32'd1);
    issue(OP_XOR, 8'h0F, 8'hFF, c6);
    check("hold_release_accept", 32'(c6 - c5), 32'd6);
    check("xor_res", 32'(res), 32'hF0);
    check("xor_flg", 32'(flg), 32'b0001);
    idle(1);

    // Shifts: SAR carry, zero amount with upper b bits set keeps C
    issue(OP_SAR, 8'h81, 8'h01, c7);
    check("sar_res", 32'(res), 32'hC0);
    check("sar_flg", 32'(flg), 32'b1001);
    issue(OP_SHL, 8'h81, 8'h08, c7);
    check("shl0_res", 32'(res), 32'h81);
    check("shl0_flg", 32'(flg), 32'b1001);
    idle(1);

    // Reset in the 4th cycle of a multiply
    issue(OP_MUL, 8'h03, 8'h05, c7);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mulrst_out_valid", 32'(out_valid), 32'd0);
    check("mulrst_busy",      32'(busy),      32'd0);
    check("mulrst_flg",       32'(flg),       32'h0);
    check("mulrst_res",       32'(res),       32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mulrst_in_ready", 32'(in_ready), 32'd1);
    issue(OP_ADD, 8'h01, 8'h01, c7);
    check("postrst_add_res", 32'(res), 32'h02);
    check("postrst_add_flg", 32'(flg), 32'b0000);
    idle(1);

    // Mixed op table, carry state threaded through the sequence
    foreach (tbl[i]) begin
      issue(tbl[i].o, tbl[i].x, tbl[i].y, c7);
      in_valid = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) begin
        @(posedge clk); #1;
      end
      check($sformatf("tbl%0d_res", i), 32'(res), 32'(tbl[i].r));
      check($sformatf("tbl%0d_flg", i), 32'(flg), 32'(tbl[i].f));
    end

    idle(3);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 8-bit combinational ALU. It adds registered results and a persistent NZVC flag register, carry-chained ops (ADC/SBC) and shifts. It also adds an optional multi-cycle shift-add multiplier. It sits between the operand/register-read stage and writeback, with valid/ready on both sides.

Parameters:
WIDTH, 8, datapath width; must be a power of two, at least 4
MUL_EN, 1, 1 = MUL implemented; 0 = MUL opcode treated as reserved
SHW, $clog2(WIDTH), derived, shift-amount width; not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept this cycle
op  in  4  opcode, see Behaviour
a  in  WIDTH  operand A
b  in  WIDTH  operand B; shift amount in b[SHW-1:0]
out_valid  out  1  res/flg valid
out_ready  in  1  consumer takes result
res  out  WIDTH  registered result
flg  out  4  flags {C,Z,V,N}: flg[3]=C, flg[2]=Z, flg[1]=V, flg[0]=N
busy  out  1  multiply in progress

Behaviour:
- Reset: res=0, flg=0, out_valid=0, busy=0, and multiplier state cleared. A reset during MUL aborts it with no result. in_ready=1 in the first cycle after rst deasserts.
- Accept: the block accepts when in_valid && in_ready, where in_ready = !busy && (!out_valid || out_ready).
- Single-cycle ops: res, flg and out_valid load at the accept edge, giving latency 1. Back-to-back throughput is 1 op per cycle while out_ready is held high.
- Output hold: out_valid stays high and res/flg stay stable until out_ready. out_valid clears on handshake unless a new op is accepted in the same cycle.
- Opcodes:
  - 0x0 AND, 0x1 OR, 0x2 XOR, 0x3 NOT a.
  - 0x4 ADD a+b; 0x5 ADC a+b+C; 0x6 SUB a+~b+1; 0x7 SBC a+~b+C.
  - 0x8 SHL, 0x9 SHR logical, 0xA SAR, each by b[SHW-1:0]; upper bits of b are ignored.
  - 0xB MUL (unsigned, low WIDTH bits of the product).
  - 0xC-0xF reserved: res=a, N/Z from res, C/V unchanged.
- Carry: ADC/SBC use the flag-register C as it stands at the accept edge, which includes the result of the immediately preceding op.
- Flags:
  - N = res[WIDTH-1]; Z = (res==0).
  - Logic ops: V=0, C unchanged.
  - Arithmetic: C = carry-out of the WIDTH-bit add. For SUB/SBC, C=1 means no borrow. V = (a[MSB]==b_eff[MSB]) && (res[MSB]!=a[MSB]), where b_eff is the actual adder operand (b or ~b).
  - Shifts: C = last bit shifted out; V=0. A shift amount of 0 gives res=a with C unchanged.
  - MUL: C = V = (high WIDTH bits of product != 0).
- MUL sequencing (MUL_EN=1):
  - The accept edge latches a and b, sets busy=1 and clears the accumulator.
  - One shift-add step per cycle for WIDTH cycles.
  - res, flg and out_valid load on the WIDTH-th step edge, and busy falls on that same edge. out_valid is therefore first seen WIDTH cycles after the accept edge.
  - in_ready=0 throughout.
- Width rules: all arithmetic is modulo 2^WIDTH; the adder is internally WIDTH+1 bits for the carry.
- Simultaneous events: a result handshake and a new accept in the same cycle are legal; the new result replaces the old with no bubble. rst overrides everything.

Decomposition:
- Package alu_pkg: opcode localparams (OP_AND..OP_MUL), flag bit indices (FLG_N=0, FLG_V=1, FLG_Z=2, FLG_C=3), flag-vector typedef.
- One sub-module, alu_mul_seq: start/done shift-add multiplier, WIDTH param, 2*WIDTH product out, clk/rst pass-through.
- The adder, shifter and logic stay inline.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01 -> res=0x80, flg=4'b0011 (C0 Z0 V1 N1); out_valid one cycle after accept.
2. ADD 0xFF+0x01 -> res=0x00, flg=4'b1100; immediately ADC 0x00+0x00 -> res=0x01, flg=4'b0000. SUB 0x05-0x05 -> res=0x00, flg=4'b1100.
3. MUL 0x10*0x11 -> res=0x10, C=1, V=1, N=0, Z=0. out_valid first high 8 cycles after the accept edge; busy=1 and in_ready=0 in between.
4. out_ready=0 while holding the ADD result 0x80: res/flg stable for 5 cycles, in_ready=0, a pending op is not accepted. Raise out_ready: the pending op is accepted in that cycle and its result appears the next cycle.
5. SAR 0x81 by 1 -> res=0xC0, C=1, N=1, V=0. SHL 0x81 by 0 -> res=0x81 with C unchanged from the prior op.
6. Assert rst on the 4th cycle of a MUL -> out_valid=0, busy=0, flg=0 immediately; in_ready=1 the cycle after rst deasserts; a following ADD 0x01+0x01 -> res=0x02.
